pattern_sequencer: RTL and testbench

Memory-game core downstream of the random-number source. Captures one 10-bit random value per game tick and reduces each to an LED index 0..9 to build a pattern. Shows the pattern on the 10 LEDs, then checks the player's button presses against it. On each pass the pattern grows by one entry until MAX_LEN is reached.

---
 rtl/pattern_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pattern_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: memory-game core that builds a random LED pattern, replays it and checks player presses.
// Ports: clk, resetn (async active-low); tick game-tick enable; randnum random source;
//        start new-game pulse; btn_valid/btn_idx player press;
//        led one-hot display; busy/await_input status; level pattern length;
//        pass/fail one-cycle round pulses; win sticky final-level flag.
module pattern_sequencer #(
    parameter int MAX_LEN       = 16,
    parameter int START_LEN     = 3,
    parameter int SHOW_TICKS    = 2,
    parameter int GAP_TICKS     = 1,
    parameter int TIMEOUT_TICKS = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic [9:0] randnum,
    input  logic       start,
    input  logic       btn_valid,
    input  logic [3:0] btn_idx,
    output logic [9:0] led,
    output logic       busy,
    output logic       await_input,
    output logic [4:0] level,
    output logic       pass,
    output logic       fail,
    output logic       win
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int TM = (SHOW_TICKS > GAP_TICKS)
                      ? ((SHOW_TICKS > TIMEOUT_TICKS) ? SHOW_TICKS : TIMEOUT_TICKS)
                      : ((GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS);
    localparam int TW = $clog2(TM + 1);

    typedef enum logic [2:0] {IDLE, GEN, SHOW_ON, SHOW_OFF, INPUT, PASS, FAIL} state_t;

    state_t        state_q, state_d;
    logic [3:0]    pat_q [MAX_LEN];
    logic [3:0]    pat_d [MAX_LEN];
    logic [4:0]    level_q, level_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, chk_ptr_q, chk_ptr_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [9:0]    led_q, led_d;
    logic          busy_q, busy_d, await_q, await_d, pass_q, pass_d, fail_q, fail_d, win_q, win_d;
    logic [3:0]    idx;
    logic          press;

    assign idx   = 4'(randnum % 10'd10);
    // Out-of-range buttons are treated as no press at all, so they neither fail nor refresh the timeout.
    assign press = btn_valid && (btn_idx <= 4'd9);

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        level_d   = level_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        chk_ptr_d = chk_ptr_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        case (state_q)
            IDLE: if (start) begin
                state_d  = GEN;
                level_d  = 5'(START_LEN);
                wr_ptr_d = '0;
                win_d    = 1'b0;
            end
            GEN: if (tick) begin
                pat_d[wr_ptr_q[AW-1:0]] = idx;
                wr_ptr_d = wr_ptr_q + 5'd1;
                if (wr_ptr_d == level_q) begin
                    state_d  = SHOW_ON;
                    rd_ptr_d = '0;
                    cnt_d    = '0;
                end
            end
            SHOW_ON: if (tick) begin
                cnt_d = cnt_q + TW'(1);
                if (cnt_d == TW'(SHOW_TICKS)) begin
                    state_d = SHOW_OFF;
                    cnt_d   = '0;
                end
            end
            SHOW_OFF: if (tick) begin
                cnt_d = cnt_q + TW'(1);
                if (cnt_d == TW'(GAP_TICKS)) begin
                    cnt_d     = '0;
                    chk_ptr_d = '0;
                    rd_ptr_d  = rd_ptr_q + 5'd1;
                    state_d   = (rd_ptr_d == level_q) ? INPUT : SHOW_ON;
                end
            end
            INPUT: begin
                // A press takes priority over a tick arriving in the same cycle.
                if (press) begin
                    if (btn_idx == pat_q[chk_ptr_q[AW-1:0]]) begin
                        chk_ptr_d = chk_ptr_q + 5'd1;
                        cnt_d     = '0;
                        if (chk_ptr_d == level_q) state_d = PASS;
                    end else begin
                        state_d = FAIL;
                    end
                end else if (tick) begin
                    cnt_d = cnt_q + TW'(1);
                    if (cnt_d == TW'(TIMEOUT_TICKS)) state_d = FAIL;
                end
            end
            PASS: if (level_q == 5'(MAX_LEN)) begin
                win_d   = 1'b1;
                state_d = IDLE;
            end else begin
                // Existing entries are kept; only the newly exposed slot gets filled.
                level_d  = level_q + 5'd1;
                wr_ptr_d = level_q;
                state_d  = GEN;
            end
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from next-state values so they can be registered without a cycle of lag;
        // pat_d forwards the final GEN write to the first SHOW_ON display.
        led_d   = (state_d == SHOW_ON) ? (10'd1 << pat_d[rd_ptr_d[AW-1:0]]) : '0;
        busy_d  = state_d != IDLE;
        await_d = state_d == INPUT;
        pass_d  = state_d == PASS;
        fail_d  = state_d == FAIL;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            level_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            chk_ptr_q <= '0;
            cnt_q     <= '0;
            led_q     <= '0;
            busy_q    <= 1'b0;
            await_q   <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            win_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            chk_ptr_q <= chk_ptr_d;
            cnt_q     <= cnt_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            await_q   <= await_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            win_q     <= win_d;
        end
    end

    always_ff @(posedge clk) pat_q <= pat_d;

    assign led         = led_q;
    assign busy        = busy_q;
    assign await_input = await_q;
    assign level       = level_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign win         = win_q;
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: randomized game scenarios checked every cycle against a pattern-level model.
module tb_pattern_sequencer;
    localparam int MAXL = 4, STL = 3, SH = 2, GP = 1, TO = 20;

    logic       clk = 1'b0, resetn = 1'b0, tick = 1'b0, start = 1'b0, btn_valid = 1'b0;
    logic [9:0] randnum = '0;
    logic [3:0] btn_idx = '0;
    logic [9:0] led;
    logic       busy, await_input, pass, fail, win;
    logic [4:0] level;
    int total = 0, bad = 0;

    pattern_sequencer #(.MAX_LEN(MAXL), .START_LEN(STL), .SHOW_TICKS(SH), .GAP_TICKS(GP), .TIMEOUT_TICKS(TO)) dut (
        .clk(clk), .resetn(resetn), .tick(tick), .randnum(randnum), .start(start),
        .btn_valid(btn_valid), .btn_idx(btn_idx), .led(led), .busy(busy),
        .await_input(await_input), .level(level), .pass(pass), .fail(fail), .win(win)
    );

    always #5 clk = ~clk;

    // Game model: phase 0 idle, 1 generating, 2 showing (m_n ticks into replay), 3 input, 4 pass, 5 fail.
    int  ph = 0, m_level = 0, m_n = 0, m_chk = 0, m_to = 0;
    bit  m_win = 1'b0, chk_en = 1'b0;
    int  m_pat[$];

    function automatic logic [19:0] model_out();
        logic [9:0] l;
        l = '0;
        if (ph == 2 && (m_n % (SH + GP)) < SH) l = 10'd1 << m_pat[m_n / (SH + GP)];
        return {l, 1'(ph != 0), 1'(ph == 3), 5'(m_level), 1'(ph == 4), 1'(ph == 5), m_win};
    endfunction

    task automatic model_step(input bit t, input int r, input bit s, input bit bv, input int bi);
        case (ph)
            0: if (s) begin ph = 1; m_level = STL; m_pat.delete(); m_win = 1'b0; end
            1: if (t) begin
                m_pat.push_back(r % 10);
                if (m_pat.size() == m_level) begin ph = 2; m_n = 0; end
            end
            2: if (t) begin
                m_n++;
                if (m_n == m_level * (SH + GP)) begin ph = 3; m_chk = 0; m_to = 0; end
            end
            3: if (bv && bi <= 9) begin
                if (bi == m_pat[m_chk]) begin
                    m_chk++; m_to = 0;
                    if (m_chk == m_level) ph = 4;
                end else ph = 5;
            end else if (t) begin
                m_to++;
                if (m_to == TO) ph = 5;
            end
            4: if (m_level == MAXL) begin m_win = 1'b1; ph = 0; end else begin m_level++; ph = 1; end
            default: ph = 0;
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) check("outputs", {12'd0, led, busy, await_input, level, pass, fail, win}, {12'd0, model_out()});

    function automatic int rnd();
        return int'($urandom_range(1023));
    endfunction

    task automatic cyc(input bit t, input int r, input bit s, input bit bv, input int bi);
        tick = t; randnum = 10'(r); start = s; btn_valid = bv; btn_idx = 4'(bi);
        @(posedge clk); #1;
        model_step(t, r, s, bv, bi);
    endtask

    task automatic press(input int v);
        cyc(bit'($urandom_range(1)), rnd(), 1'b0, 1'b1, v);
    endtask

    // Random ticks with stray start/button noise; buttons during INPUT are kept out of range.
    task automatic run_until(input int target, input string name);
        for (int k = 0; k < 500 && ph != target; k++)
            cyc(bit'($urandom_range(1)), rnd(), $urandom_range(7) == 0, $urandom_range(7) == 0,
                ph == 3 ? int'($urandom_range(15, 10)) : int'($urandom_range(15)));
        check(name, {busy, await_input}, target == 3 ? 2'b11 : 2'b00);
    endtask

    task automatic do_reset();
        resetn = 1'b0; #1;
        check("rst_led", led, 0);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_misc", {await_input, pass, fail, win}, 0);
        ph = 0; m_level = 0; m_win = 1'b0; m_pat.delete();
        tick = 1'b0; start = 1'b0; btn_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic play_correct();
        for (int k = 0; k < 200 && ph == 3; k++) begin
            if ($urandom_range(2) == 0) cyc(bit'($urandom_range(1)), rnd(), 1'b0, 1'b1, int'($urandom_range(15, 10)));
            press(m_pat[m_chk]);
        end
    endtask

    task automatic timeout_run(input int mode);
        cyc(1'b0, rnd(), 1'b1, 1'b0, 0);
        run_until(3, "to_reach");
        for (int t = 1; t <= TO; t++) begin
            cyc(1'b0, rnd(), 1'b0, mode == 1, 12);
            if (t == TO && mode == 2) begin
                cyc(1'b1, rnd(), 1'b0, 1'b1, m_pat[m_chk]);
                check("to_press_fail", fail, 0);
                check("to_press_await", await_input, 1);
            end else begin
                cyc(1'b1, rnd(), 1'b0, mode == 1 && t % 2 == 0, 13);
                check(t == TO ? "to_fire" : "to_quiet", fail, t == TO);
            end
        end
        if (mode == 2) cyc(1'b0, rnd(), 1'b0, 1'b1, (m_pat[m_chk] + 1) % 10);
        cyc(1'b0, rnd(), 1'b0, 1'b0, 0);
        check("to_idle", busy, 0);
    endtask

    task automatic play_game(input int mode, input int wrong_at);
        cyc(1'b0, rnd(), 1'b1, 1'b0, 0);
        for (int k = 0; k < 2000 && ph != 0; k++) begin
            if (ph == 3 && mode != 2 && $urandom_range(2) == 0) begin
                if (mode == 1 && m_chk == wrong_at)
                    cyc(bit'($urandom_range(1)), rnd(), 1'b0, 1'b1, (m_pat[m_chk] + 1 + int'($urandom_range(8))) % 10);
                else
                    press(m_pat[m_chk]);
            end else
                cyc(bit'($urandom_range(1)), rnd(), $urandom_range(7) == 0, $urandom_range(7) == 0,
                    ph == 3 ? int'($urandom_range(15, 10)) : int'($urandom_range(15)));
        end
        check("game_end", busy, 0);
    endtask

    initial begin
        logic [9:0] seen[$];
        logic [9:0] last;
        int vals[3];
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk_en = 1'b1;

        // Directed game: 5, 17, 1023 reduce to pattern {5,7,3}.
        vals = '{5, 17, 1023};
        cyc(1'b0, rnd(), 1'b1, 1'b0, 0);
        foreach (vals[i]) begin
            cyc(1'b0, rnd(), 1'b0, 1'b0, 0);
            cyc(1'b1, vals[i], 1'b0, 1'b0, 0);
        end
        last = '0;
        for (int k = 0; k < 300; k++) begin
            if (led != 0 && led != last) seen.push_back(led);
            last = led;
            if (ph == 3) break;
            cyc(bit'($urandom_range(1)), rnd(), $urandom_range(4) == 0, $urandom_range(4) == 0, int'($urandom_range(15)));
        end
        check("show_n", seen.size(), 3);
        if (seen.size() == 3) begin
            check("show0", seen[0], 10'h020);
            check("show1", seen[1], 10'h080);
            check("show2", seen[2], 10'h008);
        end
        check("await_after_show", await_input, 1);
        press(5); check("p5_pass", pass, 0);
        press(7); check("p7_pass", pass, 0);
        press(3); check("p3_pass", pass, 1); check("p3_level", level, 3);
        cyc(1'b0, rnd(), 1'b0, 1'b0, 0);
        check("pass_once", pass, 0); check("level4", level, 4); check("regen_busy", busy, 1);
        run_until(3, "reach_l4");
        check("model_len", m_pat.size(), 4);
        check("keep", {m_pat[0], m_pat[1], m_pat[2]}, {32'd5, 32'd7, 32'd3});
        play_correct();
        check("l4_pass", pass, 1); check("l4_win_early", win, 0);
        cyc(1'b0, rnd(), 1'b0, 1'b0, 0);
        check("win_set", win, 1); check("win_idle", busy, 0); check("win_level", level, 4);
        cyc(1'b0, rnd(), 1'b1, 1'b0, 0);
        check("restart_win", win, 0); check("restart_level", level, 3);

        // Wrong second press.
        run_until(3, "reach_wrong");
        press(m_pat[0]); check("good_nofail", fail, 0);
        press((m_pat[1] + 1) % 10); check("wrong_fail", fail, 1);
        cyc(1'b0, rnd(), 1'b0, 1'b0, 0);
        check("fail_once", fail, 0); check("fail_idle", busy, 0); check("fail_level", level, 3);

        for (int m = 0; m < 3; m++) timeout_run(m);

        // Reset mid-SHOW_ON and mid-INPUT.
        cyc(1'b0, rnd(), 1'b1, 1'b0, 0);
        for (int k = 0; k < 300 && !(ph == 2 && led != 0); k++) cyc(bit'($urandom_range(1)), rnd(), 1'b0, 1'b0, 0);
        check("mid_show_lit", led != 0, 1);
        do_reset();
        cyc(1'b0, rnd(), 1'b1, 1'b0, 0);
        run_until(3, "reach_rst_in");
        press(m_pat[0]);
        do_reset();

        for (int g = 0; g < 30; g++) play_game(int'($urandom_range(2)), int'($urandom_range(2)));

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
